// File: rtl/genius_pkg.sv
// Shared definitions for the Genius round datapath: state encoding, default width, limit clamp.
`default_nettype none

package genius_pkg;

  localparam int ROUND_W = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;
  localparam logic [1:0] ST_WIN  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_WAIT = ST_WAIT,
    S_WIN  = ST_WIN
  } state_e;

  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/step_counter.sv
// N-bit step counter with enable, synchronous clear and a registered terminal strobe on wrap.
`default_nettype none

module step_counter
  import genius_pkg::*;
#(
  parameter int N = ROUND_W
) (
  input  logic         clk_i,
  input  logic         r_n_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [N-1:0] target_i,
  output logic [N-1:0] cnt_o,
  output logic         last_o,
  output logic         tc_o
);

  logic [N-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;

  assign last_o = (cnt_q == target_i);

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (last_o) begin
        cnt_d = '0;
        tc_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + N'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge r_n_i) begin
    if (!r_n_i) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = tc_q;

endmodule

`default_nettype wire

// File: rtl/round_sequencer.sv
// Round sequencer: game FSM, round register, latched game limit and win flag around a step counter.
`default_nettype none

module round_sequencer
  import genius_pkg::*;
#(
  parameter int N           = ROUND_W,
  parameter int MAX_ROUND   = 15,
  parameter int START_ROUND = 0
) (
  input  logic         clk_i,
  input  logic         r_n_i,
  input  logic         clr_i,
  input  logic         start_i,
  input  logic         e_i,
  input  logic         adv_i,
  input  logic         rpt_i,
  input  logic [N-1:0] lim_i,
  output logic [N-1:0] step_o,
  output logic [N-1:0] round_o,
  output logic         tc_o,
  output logic         busy_o,
  output logic         win_o,
  output logic [1:0]   state_o
);

  if (MAX_ROUND > (1 << N) - 1) begin : g_chk_max_round
    $fatal(1, "round_sequencer: MAX_ROUND does not fit in N bits");
  end
  if (START_ROUND > MAX_ROUND) begin : g_chk_start_round
    $fatal(1, "round_sequencer: START_ROUND exceeds MAX_ROUND");
  end

  localparam logic [N-1:0] START_V = N'(START_ROUND);

  state_e       state_q, state_d;
  logic [N-1:0] round_q, round_d;
  logic [N-1:0] lim_q, lim_d;
  logic         win_q, win_d;
  logic         busy_q, busy_d;

  logic [N-1:0] lim_clamped;
  logic         step_last;
  logic         step_en;

  assign lim_clamped = N'(clamp_int(int'(lim_i), START_ROUND, MAX_ROUND));
  assign step_en     = (state_q == S_RUN) && e_i;

  // Clear and start both restart the step count; the counter gives clear priority over enable.
  step_counter #(.N(N)) u_step (
    .clk_i    (clk_i),
    .r_n_i    (r_n_i),
    .clr_i    (clr_i || start_i),
    .en_i     (step_en),
    .target_i (round_q),
    .cnt_o    (step_o),
    .last_o   (step_last),
    .tc_o     (tc_o)
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    lim_d   = lim_q;
    win_d   = win_q;
    if (clr_i) begin
      state_d = S_IDLE;
      round_d = START_V;
      lim_d   = START_V;
      win_d   = 1'b0;
    end else if (start_i) begin
      state_d = S_RUN;
      round_d = START_V;
      lim_d   = lim_clamped;
      win_d   = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (e_i && step_last) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (adv_i) begin
            if (round_q < lim_q) begin
              round_d = round_q + N'(1);
              state_d = S_RUN;
            end else begin
              win_d   = 1'b1;
              state_d = S_WIN;
            end
          end else if (rpt_i) begin
            state_d = S_RUN;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk_i or negedge r_n_i) begin
    if (!r_n_i) begin
      state_q <= S_IDLE;
      round_q <= START_V;
      lim_q   <= START_V;
      win_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      lim_q   <= lim_d;
      win_q   <= win_d;
      busy_q  <= busy_d;
    end
  end

  assign round_o = round_q;
  assign win_o   = win_q;
  assign busy_o  = busy_q;
  assign state_o = state_q;

endmodule

`default_nettype wire

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: tc_o scoreboard plus directed state checks.
`default_nettype none

module tb_round_sequencer;

  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         r_n_i = 1'b0;
  logic         clr_i = 1'b0, start_i = 1'b0, e_i = 1'b0, adv_i = 1'b0, rpt_i = 1'b0;
  logic [N-1:0] lim_i = '0;
  logic [N-1:0] step_o, round_o;
  logic         tc_o, busy_o, win_o;
  logic [1:0]   state_o;

  int checks = 0;
  int errors = 0;
  int exp_tc_round[$];

  round_sequencer #(.N(N), .MAX_ROUND(9), .START_ROUND(0)) dut (
    .clk_i(clk_i), .r_n_i(r_n_i), .clr_i(clr_i), .start_i(start_i), .e_i(e_i),
    .adv_i(adv_i), .rpt_i(rpt_i), .lim_i(lim_i), .step_o(step_o), .round_o(round_o),
    .tc_o(tc_o), .busy_o(busy_o), .win_o(win_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every tc_o pulse must match a queued round completion.
  always @(negedge clk_i) begin
    if (r_n_i && tc_o) begin
      if (exp_tc_round.size() == 0) begin
        chk("tc_unexpected", 1, 0);
      end else begin
        int er;
        er = exp_tc_round.pop_front();
        chk("tc_round", int'(round_o), er);
        chk("tc_state", int'(state_o), 2);
        chk("tc_step", int'(step_o), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic play_round(input int r);
    exp_tc_round.push_back(r);
    e_i = 1'b1;
    repeat (r + 1) tick();
    e_i = 1'b0;
    chk("after_round_state", int'(state_o), 2);
  endtask

  task automatic pulse_start(input int lim);
    lim_i = N'(lim); start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic pulse_adv();
    adv_i = 1'b1; tick(); adv_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) tick();
    chk("rst_state", int'(state_o), 0);
    chk("rst_step", int'(step_o), 0);
    chk("rst_round", int'(round_o), 0);
    chk("rst_tc", int'(tc_o), 0);
    chk("rst_win", int'(win_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    @(negedge clk_i); r_n_i = 1'b1;
    tick();

    // Round 0 with limit 2
    pulse_start(2);
    chk("t1_state", int'(state_o), 1);
    chk("t1_busy", int'(busy_o), 1);
    play_round(0);
    chk("t1_step", int'(step_o), 0);
    chk("t1_round", int'(round_o), 0);
    chk("t1_busy_wait", int'(busy_o), 0);

    // Play to the limit and win
    pulse_adv();
    chk("t2_round1", int'(round_o), 1);
    play_round(1);
    pulse_adv();
    chk("t2_round2", int'(round_o), 2);
    play_round(2);
    chk("t2_win_before", int'(win_o), 0);
    pulse_adv();
    chk("t2_state_win", int'(state_o), 3);
    chk("t2_win", int'(win_o), 1);
    chk("t2_round_win", int'(round_o), 2);
    e_i = 1'b1; adv_i = 1'b1; rpt_i = 1'b1; tick(); e_i = 1'b0; adv_i = 1'b0; rpt_i = 1'b0;
    chk("t2_win_hold", int'(state_o), 3);

    // rpt ignored in RUN, adv beats rpt, rpt alone replays
    pulse_start(2);
    chk("t3_restart_win", int'(win_o), 0);
    play_round(0);
    pulse_adv();
    e_i = 1'b1; tick(); e_i = 1'b0;
    chk("t3_step1", int'(step_o), 1);
    rpt_i = 1'b1; tick(); rpt_i = 1'b0;
    chk("t3_rpt_run_step", int'(step_o), 1);
    chk("t3_rpt_run_state", int'(state_o), 1);
    exp_tc_round.push_back(1);
    e_i = 1'b1; tick(); e_i = 1'b0;
    chk("t3_wait", int'(state_o), 2);
    adv_i = 1'b1; rpt_i = 1'b1; tick(); adv_i = 1'b0; rpt_i = 1'b0;
    chk("t3_adv_prio", int'(round_o), 2);
    play_round(2);
    rpt_i = 1'b1; tick(); rpt_i = 1'b0;
    chk("t3_rpt_round", int'(round_o), 2);
    chk("t3_rpt_step", int'(step_o), 0);
    chk("t3_rpt_state", int'(state_o), 1);

    // Limit 15 clamps to MAX_ROUND 9
    pulse_start(15);
    for (int r = 0; r <= 9; r++) begin
      play_round(r);
      chk("t4_round", int'(round_o), r);
      chk("t4_nowin", int'(win_o), 0);
      pulse_adv();
    end
    chk("t4_win", int'(win_o), 1);
    chk("t4_state", int'(state_o), 3);
    chk("t4_round_final", int'(round_o), 9);

    // clr in RUN mid-round
    pulse_start(15);
    for (int r = 0; r < 3; r++) begin
      play_round(r);
      pulse_adv();
    end
    e_i = 1'b1; repeat (2) tick();
    chk("t5_step2", int'(step_o), 2);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("t5_state", int'(state_o), 0);
    chk("t5_step", int'(step_o), 0);
    chk("t5_round", int'(round_o), 0);
    chk("t5_tc", int'(tc_o), 0);
    tick(); e_i = 1'b0;
    chk("t5_idle_state", int'(state_o), 0);
    chk("t5_idle_step", int'(step_o), 0);

    // Asynchronous reset in WIN
    pulse_start(1);
    play_round(0);
    pulse_adv();
    play_round(1);
    pulse_adv();
    chk("t6_win", int'(win_o), 1);
    chk("t6_round", int'(round_o), 1);
    #2 r_n_i = 1'b0;
    #1;
    chk("t6_async_win", int'(win_o), 0);
    chk("t6_async_state", int'(state_o), 0);
    chk("t6_async_round", int'(round_o), 0);
    @(negedge clk_i); r_n_i = 1'b1;
    tick();

    chk("sb_empty", exp_tc_round.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Parametrised successor to the single-round counter in the Genius game datapath.
- Counts the steps of the sequence being played or entered within the current round and flags round completion.
- Holds the round number and advances it on controller command, up to a latched game limit, then flags a win.
- Sits between the game-control FSM (start/advance/replay/clear) and the sequence memory address path (step_o).

Parameters:
N, 4, width of the step and round counters
MAX_ROUND, 15, hard ceiling on the round number; must satisfy MAX_ROUND <= 2^N-1 (elaboration-time check, fatal)
START_ROUND, 0, round value loaded at reset, on clr_i and on start_i; must satisfy START_ROUND <= MAX_ROUND

Ports:
clk_i  in  1  system clock, rising edge
r_n_i  in  1  asynchronous reset, active-low
clr_i  in  1  synchronous clear to IDLE; highest priority
start_i  in  1  begin a game; latches lim_i
e_i  in  1  step enable (one sequence element shown or entered)
adv_i  in  1  round succeeded; go to the next round
rpt_i  in  1  replay the same round (player error with retry)
lim_i  in  N  requested last round, sampled on start_i
step_o  out  N  current step index within the round
round_o  out  N  current round number
tc_o  out  1  one-cycle pulse: the round's last step was consumed
busy_o  out  1  high in RUN
win_o  out  1  sticky: the limit round was completed and advanced
state_o  out  2  FSM state, for debug and LEDs

Behaviour:
- Reset (r_n_i=0, async): state IDLE, step_o=0, round_o=START_ROUND, tc_o=0, win_o=0, limit register=START_ROUND. All outputs are registered.
- Effective limit, latched on start_i: lim = clamp(lim_i, START_ROUND, MAX_ROUND).
- clr_i=1 in any state: same values as reset, applied synchronously. All other inputs are ignored that cycle.
- IDLE (00):
  - start_i -> RUN, step_o=0, round_o=START_ROUND, limit latched.
  - e_i, adv_i and rpt_i are ignored.
- RUN (01):
  - e_i with step_o < round_o: step_o+1.
  - e_i with step_o == round_o: step_o<=0, tc_o=1 for exactly the next cycle, -> WAIT.
  - Round r therefore takes r+1 enables.
  - adv_i and rpt_i are ignored.
  - start_i restarts: step_o=0, round_o=START_ROUND, limit re-latched.
- WAIT (10):
  - adv_i with round_o < lim: round_o+1, step_o=0, -> RUN.
  - adv_i with round_o == lim: win_o<=1, round_o unchanged, -> WIN.
  - rpt_i without adv_i: step_o=0, round_o unchanged, -> RUN.
  - adv_i and rpt_i together: adv_i wins.
  - e_i is ignored.
  - start_i behaves as in RUN and has priority over adv_i/rpt_i.
- WIN (11):
  - Holds all values, win_o=1.
  - start_i -> RUN with win_o cleared and fresh counters.
  - Only clr_i or start_i leave WIN.
- tc_o is 0 in every cycle not described above. It never asserts twice without an intervening return to RUN.
- Arithmetic is unsigned N-bit.
  - step_o never exceeds round_o.
  - round_o never exceeds lim, so no wrap-around is possible.
- Reset mid-operation: asynchronous assertion forces reset values immediately. Deassertion is synchronised externally.
- busy_o = (state==RUN), registered alongside state.

Decomposition:
- Shared package genius_pkg:
  - state encoding localparams ST_IDLE=2'b00, ST_RUN=2'b01, ST_WAIT=2'b10, ST_WIN=2'b11.
  - default ROUND_W=4.
- Natural sub-module: step_counter, an N-bit counter with enable, synchronous clear and compare-to-target producing a terminal strobe.
- round_sequencer instantiates step_counter and owns the FSM, the round register, the limit clamp and win_o.

Test Plan:
1. Reset, then start_i with lim_i=2, then 1 enable -> tc_o pulses 1 cycle after the enable; state WAIT; step_o=0; round_o=0.
2. From 1: adv_i, 2 enables -> tc_o once; adv_i, 3 enables -> tc_o; adv_i -> win_o=1, state WIN, round_o=2.
3. Round 1 after 1 enable (step_o=1): rpt_i must be ignored in RUN. Complete the round, then assert adv_i and rpt_i together -> round_o=2 (adv priority). Separately, rpt_i alone in WAIT -> round_o unchanged, step_o=0.
4. start_i with lim_i=15 and MAX_ROUND=9 -> play through; win_o asserts after the round-9 adv_i; round_o never exceeds 9.
5. clr_i in RUN at step 2 of round 3 while e_i=1 -> next cycle IDLE, step_o=0, round_o=0, tc_o=0; e_i in IDLE has no effect.
6. r_n_i pulled low mid-cycle in WIN -> outputs reset without waiting for a clock edge; win_o=0, state_o=00.
